// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter producing 8N1/8N2 frames on txd.
// Bits are sent LSB first. Each bit lasts TICKS_PER_BIT clk cycles.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s), giving 8E1/8E2 frames.
// rdy_tx and txd are both registered outputs.

module uart_tx #(
  parameter int TICKS_PER_BIT = 10417,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d_tx,
  input  logic       vld_tx,
  output logic       rdy_tx,
  output logic       txd
);

  // Width of the tick counter; keep at least one bit.
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  // Any STOP_BITS value other than 2 is treated as a single stop bit.
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          rdy_q, rdy_d;
  logic          tick_end;
  logic          accept;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign tick_end = (tick_q == TICK_LAST);
  assign accept   = vld_tx & rdy_q;
  assign rdy_tx   = rdy_q;
  assign txd      = txd_q;

  // Register stage: synchronous active-low reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      rdy_q   <= rdy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity bit is captured once, from the byte as it is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Next-state logic: tick counter, bit counter, shift register and FSM.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != IDLE) begin
      tick_d = tick_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = d_tx;
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^d_tx;
`endif
        end
      end
      START: begin
        if (tick_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
`endif
      STOP: begin
        if (tick_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so txd and rdy_tx come straight from flops.
  always_comb begin
    rdy_d = (state_d == IDLE);
    txd_d = 1'b1;
    case (state_d)
      START:  txd_d = 1'b0;
      DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx with TICKS_PER_BIT=16.
// Instance dut uses one stop bit, instance dut2 uses two stop bits.
// Expectations follow UART_TX_PARITY_EN when it is defined for the build.

module tb_uart_tx;

  localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [0:9] line;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d1, d2;
  logic       vld1, vld2;
  logic       rdy1, txd1, rdy2, txd2;

  int checks = 0;
  int passes = 0;

  vec_t vecs [11];

  always #5 clk = ~clk;

  uart_tx #(.TICKS_PER_BIT(TPB), .STOP_BITS(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_tx   (d1),
    .vld_tx (vld1),
    .rdy_tx (rdy1),
    .txd    (txd1)
  );

  uart_tx #(.TICKS_PER_BIT(TPB), .STOP_BITS(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_tx   (d2),
    .vld_tx (vld2),
    .rdy_tx (rdy2),
    .txd    (txd2)
  );

  function automatic logic sel_txd(input int which);
    return (which != 0) ? txd2 : txd1;
  endfunction

  function automatic logic sel_rdy(input int which);
    return (which != 0) ? rdy2 : rdy1;
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input int which, input logic [7:0] data, input logic vld);
    if (which != 0) begin
      d2 = data;
      vld2 = vld;
    end else begin
      d1 = data;
      vld1 = vld;
    end
  endtask

  // Waits (bounded) for rdy_tx, presents the byte, and returns at the
  // falling edge right after the accepting rising edge.
  task automatic applyStimulus(input int which, input logic [7:0] data);
    int n = 0;
    while (sel_rdy(which) !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rdy_before_send", sel_rdy(which), 1'b1);
    drive(which, data, 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic exp_bit(input vec_t v, input int k);
    if (k <= 8) return v.line[k];
    if (PAR == 1 && k == 9) return v.par;
    return 1'b1;
  endfunction

  // Called at the falling edge right after the accept edge. Checks each bit at
  // its first, middle and last cycle, rdy_tx low all frame and high on time.
  // Returns at the falling edge after rdy_tx should have risen.
  task automatic frameCheck(input int which, input vec_t v, input int stops,
                            input logic keep_vld, input logic [7:0] d_during);
    int nbits;
    int frame_len;
    int k;
    int t;
    nbits = 10 + PAR + stops - 1;
    frame_len = nbits * TPB;
    drive(which, d_during, keep_vld);
    checkOutput("start_bit_now", sel_txd(which), 1'b0);
    checkOutput("rdy_low_after_accept", sel_rdy(which), 1'b0);
    for (int c = 0; c < frame_len; c++) begin
      if (c > 0) @(negedge clk);
      k = c / TPB;
      t = c % TPB;
      if (t == 0 || t == TPB / 2 || t == TPB - 1) begin
        checkOutput($sformatf("data%02h_bit%0d_t%0d", v.data, k, t),
                    sel_txd(which), exp_bit(v, k));
      end
      if (t == TPB / 2) begin
        checkOutput($sformatf("data%02h_rdy_busy_bit%0d", v.data, k), sel_rdy(which), 1'b0);
      end
    end
    checkOutput($sformatf("data%02h_rdy_last_cycle", v.data), sel_rdy(which), 1'b0);
    @(negedge clk);
    checkOutput($sformatf("data%02h_rdy_end", v.data), sel_rdy(which), 1'b1);
    checkOutput($sformatf("data%02h_idle_line", v.data), sel_txd(which), 1'b1);
  endtask

  initial begin
    logic all_high;

    // Line patterns in wire order: start, d0..d7, stop; par = even parity.
    vecs[0]  = '{data: 8'hA5, line: 10'b0_10100101_1, par: 1'b0};
    vecs[1]  = '{data: 8'h00, line: 10'b0_00000000_1, par: 1'b0};
    vecs[2]  = '{data: 8'hFF, line: 10'b0_11111111_1, par: 1'b0};
    vecs[3]  = '{data: 8'h3C, line: 10'b0_00111100_1, par: 1'b0};
    vecs[4]  = '{data: 8'h55, line: 10'b0_10101010_1, par: 1'b0};
    vecs[5]  = '{data: 8'h07, line: 10'b0_11100000_1, par: 1'b1};
    vecs[6]  = '{data: 8'h03, line: 10'b0_11000000_1, par: 1'b0};
    vecs[7]  = '{data: 8'h81, line: 10'b0_10000001_1, par: 1'b0};
    vecs[8]  = '{data: 8'h01, line: 10'b0_10000000_1, par: 1'b1};
    vecs[9]  = '{data: 8'h80, line: 10'b0_00000001_1, par: 1'b1};
    vecs[10] = '{data: 8'hC3, line: 10'b0_11000011_1, par: 1'b0};

    rst_n = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);

    // Reset held for three cycles, then released; line idles high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_txd", txd1, 1'b1);
    checkOutput("reset_rdy", rdy1, 1'b1);
    checkOutput("reset_txd2", txd2, 1'b1);
    checkOutput("reset_rdy2", rdy2, 1'b1);
    rst_n = 1'b1;
    all_high = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      all_high = all_high & txd1 & rdy1;
    end
    checkOutput("idle_100_cycles", all_high, 1'b1);

    // Table-driven single frames with a one-cycle vld_tx pulse.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, vecs[i].data);
      frameCheck(0, vecs[i], 1, 1'b0, ~vecs[i].data);
    end

    // Back-to-back: vld_tx held high, d_tx changed to FF during the 00 frame.
    applyStimulus(0, 8'h00);
    frameCheck(0, vecs[1], 1, 1'b1, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    frameCheck(0, vecs[2], 1, 1'b0, 8'h12);

    // Reset in the middle of data bit 4 of 3C, then a clean 55 frame.
    applyStimulus(0, 8'h3C);
    drive(0, 8'h3C, 1'b0);
    repeat (5 * TPB + TPB / 2) @(negedge clk);
    checkOutput("pre_reset_bit4", txd1, 1'b1);
    checkOutput("pre_reset_busy", rdy1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midframe_reset_txd", txd1, 1'b1);
    checkOutput("midframe_reset_rdy", rdy1, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 8'h55);
    frameCheck(0, vecs[4], 1, 1'b0, 8'h00);

    // Two stop bits on the second instance.
    applyStimulus(1, 8'h81);
    frameCheck(1, vecs[7], 2, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety net so the run always ends, even if a wait above misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, limit 2000000 reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
